// File: rtl/step_pulse_if.sv
// step_pulse_if: control, config and status bundle of the step pulse generator
interface step_pulse_if #(
  parameter int DW = 14,
  parameter int CW = 16
);
  logic          start;
  logic          stop;
  logic [DW-1:0] amplitude;
  logic [CW-1:0] dwell_low;
  logic [CW-1:0] dwell_high;
  logic [CW-1:0] num_pulses;
  logic [DW-1:0] signal;
  logic          steprise;
  logic          stepfall;
  logic          busy;
  logic          done;
  logic [CW-1:0] pulse_cnt;
  modport master (
    output start, stop, amplitude, dwell_low, dwell_high, num_pulses,
    input  signal, steprise, stepfall, busy, done, pulse_cnt
  );
  modport slave (
    input  start, stop, amplitude, dwell_low, dwell_high, num_pulses,
    output signal, steprise, stepfall, busy, done, pulse_cnt
  );
endinterface

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: burst generator of rectangular steps above a baseline, with edge markers
module step_pulse_gen #(
  parameter int            DW   = 14,
  parameter logic [DW-1:0] BASE = DW'(8192),
  parameter int            CW   = 16
) (
  input logic       clk,
  input logic       rst,
  step_pulse_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] dl_q, dl_d;
  logic [CW-1:0] dh_q, dh_d;
  logic [CW-1:0] np_q, np_d;
  logic [CW-1:0] pc_q, pc_d;
  logic [DW-1:0] top_q, top_d;
  logic [DW-1:0] signal_q;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          busy_q, done_q;
  logic [DW:0]   sum;
  logic [CW-1:0] dl_in, dh_in;
  assign sum   = {1'b0, BASE} + {1'b0, bus.amplitude};
  assign dl_in = (bus.dwell_low == '0) ? CW'(1) : bus.dwell_low;
  assign dh_in = (bus.dwell_high == '0) ? CW'(1) : bus.dwell_high;
  // Counter expires when it reaches 1, so a loaded value N gives N cycles in the level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    dh_d    = dh_q;
    np_d    = np_q;
    pc_d    = pc_q;
    top_d   = top_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        top_d   = sum[DW] ? '1 : sum[DW-1:0];
        dl_d    = dl_in;
        dh_d    = dh_in;
        np_d    = bus.num_pulses;
        pc_d    = '0;
        cnt_d   = dl_in;
        state_d = LOW;
      end
      LOW: if (bus.stop) begin
        state_d = DONE;
      end else if (cnt_q <= CW'(1)) begin
        state_d = HIGH;
        rise_d  = 1'b1;
        cnt_d   = dh_q;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      HIGH: if (bus.stop) begin
        fall_d  = 1'b1;
        state_d = DONE;
      end else if (cnt_q <= CW'(1)) begin
        fall_d  = 1'b1;
        pc_d    = pc_q + CW'(1);
        state_d = (np_q != '0 && pc_d == np_q) ? DONE : LOW;
        cnt_d   = dl_q;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dl_q     <= '0;
      dh_q     <= '0;
      np_q     <= '0;
      pc_q     <= '0;
      top_q    <= BASE;
      signal_q <= BASE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dl_q     <= dl_d;
      dh_q     <= dh_d;
      np_q     <= np_d;
      pc_q     <= pc_d;
      top_q    <= top_d;
      signal_q <= (state_d == HIGH) ? top_q : BASE;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= (state_d == LOW) || (state_d == HIGH);
      done_q   <= (state_d == DONE);
    end
  end
  assign bus.signal    = signal_q;
  assign bus.steprise  = rise_q;
  assign bus.stepfall  = fall_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pulse_cnt = pc_q;
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: randomized scenarios checked against an arithmetic waveform model
module tb_step_pulse_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  step_pulse_if #(.DW(14), .CW(16)) bus ();
  step_pulse_gen dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Expected {signal, steprise, stepfall, busy, done, pulse_cnt} k edges after the start edge.
  function automatic logic [33:0] model(int k, int dl, int dh, int n, int top, int s, int r);
    int  p = dl + dh;
    int  endk = (n == 0) ? 32'h3fff_ffff : n * p;
    int  pc;
    logic hi, hi_prev, rise, fall;
    if (r > 0 && k >= r) return {14'd8192, 4'b0000, 16'd0};
    if (s > 0 && s <= endk) begin
      hi_prev = (k - 1) >= 1 && ((k - 1) % p) >= dl;
      if (k == s) return {14'd8192, 1'b0, hi_prev, 1'b0, 1'b1, 16'((s - 1) / p)};
      if (k > s) return {14'd8192, 4'b0000, 16'((s - 1) / p)};
    end
    hi   = k >= 1 && k < endk && (k % p) >= dl;
    rise = k >= 1 && k < endk && (k % p) == dl;
    fall = k >= 1 && k <= endk && (k % p) == 0;
    pc   = (n != 0 && k / p > n) ? n : k / p;
    return {hi ? 14'(top) : 14'd8192, rise, fall, 1'(k < endk), 1'(k == endk), 16'(pc)};
  endfunction
  task automatic run_burst(input string name, input int amp, input int dl_in, input int dh_in,
                           input int n, input int s, input int r, input int noise, input int extra);
    int dl, dh, p, top, endk, last;
    logic [33:0] got, want;
    dl   = (dl_in == 0) ? 1 : dl_in;
    dh   = (dh_in == 0) ? 1 : dh_in;
    p    = dl + dh;
    top  = (8192 + amp > 16383) ? 16383 : 8192 + amp;
    endk = (n == 0) ? 32'h3fff_ffff : n * p;
    if (s > 0 && s <= endk) endk = s;
    last = (r > 0) ? r : endk + extra;
    bus.amplitude  = 14'(amp);
    bus.dwell_low  = 16'(dl_in);
    bus.dwell_high = 16'(dh_in);
    bus.num_pulses = 16'(n);
    for (int k = 0; k <= last; k++) begin
      bus.start = (k == 0) || (noise != 0 && k <= endk + 1 && $urandom_range(1) == 1);
      bus.stop  = (k == s) || (s == 0 && k == endk + 1);
      rst       = (r > 0 && k == r);
      if (noise != 0 && k > 0) begin
        bus.amplitude  = 14'($urandom);
        bus.dwell_low  = 16'($urandom_range(7));
        bus.dwell_high = 16'($urandom_range(7));
        bus.num_pulses = 16'($urandom_range(5));
      end
      @(posedge clk);
      #1;
      got  = {bus.signal, bus.steprise, bus.stepfall, bus.busy, bus.done, bus.pulse_cnt};
      want = model(k, dl, dh, n, top, s, r);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s k=%0d got sig=%0d rise=%b fall=%b busy=%b done=%b cnt=%0d, expected sig=%0d rise=%b fall=%b busy=%b done=%b cnt=%0d",
                 name, k, got[33:20], got[19], got[18], got[17], got[16], got[15:0],
                 want[33:20], want[19], want[18], want[17], want[16], want[15:0]);
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b0;
  endtask
  task automatic test_reset();
    logic [33:0] got;
    rst = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.signal, bus.steprise, bus.stepfall, bus.busy, bus.done, bus.pulse_cnt};
    n_checks++;
    if (got !== {14'd8192, 4'b0000, 16'd0}) begin
      n_fail++;
      $display("FAIL reset got=%h expected=%h", got, {14'd8192, 4'b0000, 16'd0});
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    run_burst("basic", 100, 4, 3, 2, 0, 0, 0, 2);
    run_burst("zero_amp", 0, 2, 3, 2, 0, 0, 0, 2);
  endtask
  task automatic test_saturate();
    run_burst("saturate", 9000, 4, 3, 2, 0, 0, 0, 2);
    run_burst("sat_edge", 8191, 1, 2, 1, 0, 0, 0, 2);
  endtask
  task automatic test_zero_dwell();
    run_burst("zero_dwell", 300, 0, 0, 3, 0, 0, 0, 2);
  endtask
  task automatic test_stop();
    run_burst("stop_high", 1234, 2, 2, 0, 20, 0, 0, 2);
    run_burst("stop_low", 55, 3, 2, 0, 7, 0, 0, 2);
    run_burst("stop_at_expiry", 77, 2, 3, 2, 10, 0, 0, 2);
  endtask
  task automatic test_noise();
    run_burst("noise", 500, 3, 2, 3, 0, 0, 1, 2);
    run_burst("noise_cont", 600, 1, 3, 0, 15, 0, 1, 2);
  endtask
  task automatic test_back_to_back();
    run_burst("b2b_a", 40, 2, 1, 2, 0, 0, 0, 1);
    run_burst("b2b_b", 80, 1, 1, 1, 0, 0, 0, 1);
    run_burst("b2b_c", 160, 3, 2, 1, 0, 0, 0, 2);
  endtask
  task automatic test_rst_mid();
    run_burst("rst_mid", 100, 4, 3, 2, 0, 6, 0, 0);
    run_burst("after_rst", 50, 2, 2, 2, 0, 0, 0, 2);
  endtask
  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int amp = $urandom_range(16383);
      int dl  = $urandom_range(5);
      int dh  = $urandom_range(5);
      int n   = $urandom_range(4, 1);
      int p   = (dl == 0 ? 1 : dl) + (dh == 0 ? 1 : dh);
      int s   = ($urandom_range(2) == 0) ? $urandom_range(n * p, 1) : 0;
      run_burst("random", amp, dl, dh, n, s, 0, $urandom_range(1), 2);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.amplitude = '0;
    bus.dwell_low = '0;
    bus.dwell_high = '0;
    bus.num_pulses = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_zero_dwell();
    test_stop();
    test_noise();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
